// File: rtl/ldpc_bitflip_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_bitflip_decoder
// Description : Iterative hard-decision bit-flipping decoder for cyclic LDPC
//               codes. Parity matrix row r is H_BASE rotated left by r.
//               Each iteration registers the syndrome and then inverts every
//               bit whose unsatisfied-check count reaches FLIP_THRESH.
//               Decoding stops on a zero syndrome, when MAX_ITER iterations
//               have been used, or when no bit qualifies for a flip.
// Ports       : clk, rst_n (sync, active-low)
//               in_valid/in_ready/in_data        - received codeword stream
//               out_valid/out_ready/out_data     - corrected codeword stream
//               out_fail, out_flipped, out_iter  - decode status
//               out_syndrome                     - final syndrome
//               stat_words, stat_fails           - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module ldpc_bitflip_decoder #(
    parameter int unsigned  N           = 15,
    parameter logic [N-1:0] H_BASE      = 15'h00D1,
    parameter int unsigned  FLIP_THRESH = 3,
    parameter int unsigned  MAX_ITER    = 4,
    parameter int unsigned  CNT_W       = 16,
    // Iteration counter width; kept at least one bit so MAX_ITER=0 still
    // yields a legal port.
    parameter int unsigned  ITER_W      = (MAX_ITER > 0) ? $clog2(MAX_ITER + 1) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic              out_fail,
    output logic              out_flipped,
    output logic [ITER_W-1:0] out_iter,
    output logic [N-1:0]      out_syndrome,
    output logic [CNT_W-1:0]  stat_words,
    output logic [CNT_W-1:0]  stat_fails
);

    localparam int unsigned POP_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYND = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [N-1:0]      r_word;
    logic [N-1:0]      r_synd;
    logic [ITER_W-1:0] r_iter;
    logic              r_fail;
    logic              r_flipped;
    logic [CNT_W-1:0]  r_stat_words;
    logic [CNT_W-1:0]  r_stat_fails;

    logic [N-1:0]      w_synd;
    logic [N-1:0]      w_flip;
    logic              w_synd_zero;
    logic              w_at_max;
    logic              w_any_flip;

    // ------------------------------------------------------------------
    // Syndrome of the working word: row r of H is H_BASE rotated left by r.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < N; r++) begin : g_row
        localparam logic [N-1:0] c_row = (H_BASE << r) | (H_BASE >> ((N - r) % N));
        assign w_synd[r] = ^(r_word & c_row);
    end

    // ------------------------------------------------------------------
    // Per-column unsatisfied-check count and flip decision, taken from the
    // registered syndrome so EVAL sees a stable value.
    // ------------------------------------------------------------------
    for (genvar j = 0; j < N; j++) begin : g_col
        logic [N-1:0]     w_hit;
        logic [POP_W-1:0] w_cnt;

        for (genvar r = 0; r < N; r++) begin : g_hit
            assign w_hit[r] = r_synd[r] & H_BASE[(j - r + N) % N];
        end

        always_comb begin
            w_cnt = '0;
            for (int k = 0; k < N; k++) begin
                w_cnt = w_cnt + POP_W'(w_hit[k]);
            end
        end

        assign w_flip[j] = (32'(w_cnt) >= FLIP_THRESH);
    end

    assign w_synd_zero = (r_synd == '0);
    assign w_any_flip  = |w_flip;
    assign w_at_max    = (32'(r_iter) == MAX_ITER);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_SYND;
                end
            end
            S_SYND: begin
                w_state_next = S_EVAL;
            end
            S_EVAL: begin
                // Success, iteration budget spent, or a stall all finish.
                if (w_synd_zero || w_at_max || !w_any_flip) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_SYND;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word       <= '0;
            r_synd       <= '0;
            r_iter       <= '0;
            r_fail       <= 1'b0;
            r_flipped    <= 1'b0;
            r_stat_words <= '0;
            r_stat_fails <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_word    <= in_data;
                        r_iter    <= '0;
                        r_fail    <= 1'b0;
                        r_flipped <= 1'b0;
                    end
                end
                S_SYND: begin
                    r_synd <= w_synd;
                end
                S_EVAL: begin
                    if (!w_synd_zero) begin
                        if (w_at_max || !w_any_flip) begin
                            r_fail <= 1'b1;
                        end else begin
                            r_word    <= r_word ^ w_flip;
                            r_iter    <= r_iter + ITER_W'(1);
                            r_flipped <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        if (r_stat_words != '1) begin
                            r_stat_words <= r_stat_words + CNT_W'(1);
                        end
                        if (r_fail && (r_stat_fails != '1)) begin
                            r_stat_fails <= r_stat_fails + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data     = r_word;
    assign out_syndrome = r_synd;
    assign out_iter     = r_iter;
    assign out_fail     = r_fail;
    assign out_flipped  = r_flipped;
    assign stat_words   = r_stat_words;
    assign stat_fails   = r_stat_fails;

endmodule
`default_nettype wire
